// File: rtl/cla_arbiter.sv
// cla_arbiter: two-requester round-robin front end that time-shares a single
// 32-bit carry-lookahead adder (cla_32). One operation is in flight at a time:
// IDLE (accept) -> CALC (adder evaluates registered operands) -> HOLD (result
// presented until the consumer takes it).
// Optional subtract mode: define CLA_ARB_SUB_EN to add req0_sub/req1_sub.

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out,
  output logic        overflow
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  bg;
  logic [7:0]  bp;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Block generate/propagate for each 4-bit lookahead group
  always_comb begin
    bg = '0;
    bp = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      bp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Carries: lookahead inside each group, group carry chained via bg/bp
  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = bg[k] | (bp[k] & c[4*k]);
    end
  end

  assign s        = p ^ c[31:0];
  assign c_out    = c[32];
  assign overflow = (a[31] == b[31]) & (s[31] != a[31]);

endmodule

module cla_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_c_in,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_c_in,
`ifdef CLA_ARB_SUB_EN
  input  logic        req0_sub,
  input  logic        req1_sub,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_c_out,
  output logic        rsp_overflow
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic        grant0;
  logic        grant1;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_c_in;
  logic        op_id;
  logic [31:0] add_b;
  logic        add_c_in;
  logic [31:0] sum;
  logic        sum_c;
  logic        sum_ov;
`ifdef CLA_ARB_SUB_EN
  logic        op_sub;
`endif

  // Grant selection and next-state; the requester not holding `last` wins a tie
  always_comb begin
    state_nxt = state;
    grant0    = '0;
    grant1    = '0;
    case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | last);
        grant1 = req1_valid & (~req0_valid | ~last);
        if (grant0 | grant1) state_nxt = CALC;
      end
      CALC:    state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are masked by rst_n so they read 0 for the whole reset window
  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;
  assign rsp_valid  = (state == HOLD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Last-grant pointer, updated on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= ~RR_INIT;
    else if (grant0 | grant1)  last <= grant1;
  end

  // Operand capture on the accept edge; the adder sees only these registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_c_in <= '0;
      op_id   <= '0;
`ifdef CLA_ARB_SUB_EN
      op_sub  <= '0;
`endif
    end else if (grant0 | grant1) begin
      op_a    <= grant1 ? req1_a    : req0_a;
      op_b    <= grant1 ? req1_b    : req0_b;
      op_c_in <= grant1 ? req1_c_in : req0_c_in;
      op_id   <= grant1;
`ifdef CLA_ARB_SUB_EN
      op_sub  <= grant1 ? req1_sub  : req0_sub;
`endif
    end
  end

`ifdef CLA_ARB_SUB_EN
  // Subtract as a + ~b + 1; the requester's carry-in is ignored
  assign add_b    = op_sub ? ~op_b : op_b;
  assign add_c_in = op_sub | op_c_in;
`else
  assign add_b    = op_b;
  assign add_c_in = op_c_in;
`endif

  cla_32 u_cla (
    .a        (op_a),
    .b        (add_b),
    .c_in     (add_c_in),
    .s        (sum),
    .c_out    (sum_c),
    .overflow (sum_ov)
  );

  // Response registers load on CALC exit and hold through HOLD backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_s        <= '0;
      rsp_c_out    <= '0;
      rsp_overflow <= '0;
      rsp_id       <= '0;
    end else if (state == CALC) begin
      rsp_s        <= sum;
      rsp_c_out    <= sum_c;
      rsp_overflow <= sum_ov;
      rsp_id       <= op_id;
    end
  end

endmodule

// File: tb/tb_cla_arbiter.sv
// tb_cla_arbiter: directed vectors for cla_arbiter with an arithmetic reference
// model checked every cycle, plus literal expectations for key scenarios.
// Subtract vectors are included when CLA_ARB_SUB_EN is defined.

module tb_cla_arbiter;

  localparam logic RR_INIT = 1'b0;
`ifdef CLA_ARB_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_c_in = 1'b0, req1_c_in = 1'b0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_ready = 1'b1;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_c_out, rsp_overflow;
  logic [31:0] rsp_s;

  int vectors = 0;
  int miscompares = 0;
  int grants[$];
  int ids[$];

  always #5 clk = ~clk;

  cla_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_c_in    (req0_c_in),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_c_in    (req1_c_in),
`ifdef CLA_ARB_SUB_EN
    .req0_sub     (req0_sub),
    .req1_sub     (req1_sub),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_s        (rsp_s),
    .rsp_c_out    (rsp_c_out),
    .rsp_overflow (rsp_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic        m_last = ~RR_INIT;
  logic [31:0] m_s = '0, q_s = '0;
  logic        m_c = 1'b0, m_ov = 1'b0, m_id = 1'b0;
  logic        q_c = 1'b0, q_ov = 1'b0, q_id = 1'b0;

  // {overflow, carry, sum} from plain arithmetic
  function automatic logic [33:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sub);
    logic [32:0] t;
    logic [31:0] s;
    logic        co, ov;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      ov = (a[31] != b[31]) && (s[31] != a[31]);
    end else begin
      t  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
      s  = t[31:0];
      co = t[32];
      ov = (a[31] == b[31]) && (s[31] != a[31]);
    end
    return {ov, co, s};
  endfunction

  function automatic logic exp_ready(input int n);
    logic both;
    both = req0_valid && req1_valid;
    if (!rst_n || m_busy) return 1'b0;
    if (n == 0) return req0_valid && (!both || m_last == 1'b1);
    return req1_valid && (!both || m_last == 1'b0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_last <= ~RR_INIT;
      m_s <= '0; m_c <= 1'b0; m_ov <= 1'b0; m_id <= 1'b0;
    end else if (!m_busy) begin
      if (exp_ready(0) || exp_ready(1)) begin
        {q_ov, q_c, q_s} <= exp_ready(1) ? golden(req1_a, req1_b, req1_c_in, req1_sub & SUB_EN)
                                         : golden(req0_a, req0_b, req0_c_in, req0_sub & SUB_EN);
        q_id   <= exp_ready(1);
        m_last <= exp_ready(1);
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end
    end else if (m_cnt == 1) begin
      m_cnt <= 2;
      m_s <= q_s; m_c <= q_c; m_ov <= q_ov; m_id <= q_id;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end
  end

  // Per-cycle comparison against the model, plus grant/response logging
  always @(negedge clk) begin
    check("req0_ready",   32'(req0_ready),   32'(exp_ready(0)));
    check("req1_ready",   32'(req1_ready),   32'(exp_ready(1)));
    check("rsp_valid",    32'(rsp_valid),    32'(m_busy && m_cnt == 2));
    check("rsp_s",        rsp_s,             m_s);
    check("rsp_c_out",    32'(rsp_c_out),    32'(m_c));
    check("rsp_overflow", 32'(rsp_overflow), 32'(m_ov));
    check("rsp_id",       32'(rsp_id),       32'(m_id));
    if (req0_valid && req0_ready) grants.push_back(0);
    if (req1_valid && req1_ready) grants.push_back(1);
    if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub, input logic v);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_c_in = ci; req0_sub = sub;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_c_in = ci; req1_sub = sub;
    end
  endtask

  task automatic wait_rsp(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid;
    end
    check("rsp_wait", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sub, output int lat);
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    drive(n, a, b, ci, sub, 1'b1);
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = (n == 0) ? req0_ready : req1_ready;
    end
    check("accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    drive(n, a, b, ci, sub, 1'b0);
    wait_rsp(lat);
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] s, input logic c,
                           input logic ov, input logic id);
    check({tag, "_s"},  rsp_s,             s);
    check({tag, "_c"},  32'(rsp_c_out),    32'(c));
    check({tag, "_ov"}, 32'(rsp_overflow), 32'(ov));
    check({tag, "_id"}, 32'(rsp_id),       32'(id));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(rsp_valid),  32'd0);
    check({tag, "_rdy0"},  32'(req0_ready), 32'd0);
    check({tag, "_rdy1"},  32'(req1_ready), 32'd0);
    check_rsp(tag, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    // Reset with req0 already valid: readies must stay low during reset
    #1 rst_n = 1'b0;
    drive(0, 32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    // First IDLE cycle after release accepts
    @(negedge clk);
    check("first_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(lat);
    check("basic_latency", 32'(lat), 32'd2);
    check_rsp("basic", 32'h00000010, 1'b0, 1'b0, 1'b0);

    run_op(0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, lat);
    check_rsp("minmin", 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    check_rsp("posovf", 32'h80000000, 1'b0, 1'b1, 1'b1);
    run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat);
    check_rsp("cin_wrap", 32'h00000000, 1'b1, 1'b0, 1'b0);
`ifdef CLA_ARB_SUB_EN
    run_op(1, 32'd5, 32'd7, 1'b1, 1'b1, lat);
    check_rsp("sub_neg", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    run_op(0, 32'd7, 32'd5, 1'b0, 1'b1, lat);
    check_rsp("sub_pos", 32'h00000002, 1'b1, 1'b0, 1'b0);
`endif

    // Round robin from reset with both requesters continuously valid
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    grants.delete();
    ids.delete();
    drive(0, 32'd100, 32'd1, 1'b0, 1'b0, 1'b1);
    drive(1, 32'd200, 32'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 60 && grants.size() < 4; k++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 20 && ids.size() < 4; k++) @(negedge clk);
    check("grant_count", 32'(grants.size()), 32'd4);
    check("id_count",    32'(ids.size()),    32'd4);
    for (int i = 0; i < 4 && i < grants.size() && i < ids.size(); i++) begin
      check($sformatf("grant_order%0d", i), 32'(grants[i]), 32'(i % 2));
      check($sformatf("rsp_id_order%0d", i), 32'(ids[i]), 32'(i % 2));
    end

    // Backpressure in HOLD with a second requester waiting
    @(posedge clk); #1 rsp_ready = 1'b0;
    run_op(0, 32'd1, 32'd2, 1'b0, 1'b0, lat);
    check_rsp("bp_first", 32'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdy0",  32'(req0_ready), 32'd0);
      check("bp_rdy1",  32'(req1_ready), 32'd0);
      check_rsp("bp_hold", 32'd3, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_valid", 32'(rsp_valid),  32'd0);
    check("bp_late_rdy1",  32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(lat);
    check("bp_late_latency", 32'(lat), 32'd2);
    check_rsp("bp_late", 32'd30, 1'b0, 1'b0, 1'b1);

    // Reset during CALC discards the operation
    @(posedge clk); #1 drive(0, 32'h00001234, 32'h00000001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("abort_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("abort_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(1, 32'd40, 32'd2, 1'b1, 1'b0, lat);
    check("abort_after_latency", 32'(lat), 32'd2);
    check_rsp("abort_after", 32'd43, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cla_arbiter.md
CLA_ARBITER -- requirements
Module: cla_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: the operands.
REQ-007 SHALL have ports req0_c_in and req1_c_in, input, 1 bit each: the carry-in.
REQ-008 SHALL have port rsp_valid, output, 1 bit: a result is held on the response port.
REQ-009 SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the result.
REQ-011 SHALL have port rsp_s, output, 32 bits: the sum.
REQ-012 SHALL have ports rsp_c_out and rsp_overflow, output, 1 bit each: the carry-out and the signed overflow.

Function
REQ-013 SHALL instantiate exactly one CLA_32 and time-share it between both requesters; the adder SHALL be driven only from internal operand registers.
REQ-014 SHALL implement the FSM states IDLE, CALC and HOLD.
- IDLE to CALC: on a grant.
- CALC to HOLD: unconditionally after 1 cycle.
- HOLD to IDLE: on rsp_valid && rsp_ready.
REQ-015 SHALL assert reqN_ready only in IDLE, only for the granted requester, and never for both requesters in the same cycle; reqN_ready may depend combinationally on reqN_valid.
REQ-016 SHALL grant as follows:
- only one requester valid: grant that requester.
- both valid: grant the requester that does not hold the last-grant pointer.
- the last-grant pointer SHALL update on every grant.
REQ-017 SHALL, on the accept edge, capture a, b, c_in and the requester index into the operand registers.
REQ-018 SHALL, on the CALC-exit edge, register the CLA_32 outputs s, c_out and overflow into rsp_s, rsp_c_out and rsp_overflow.
REQ-019 SHALL assert rsp_valid exactly in HOLD; results are available 2 cycles after the accept edge.
REQ-020 SHALL keep rsp_s, rsp_c_out, rsp_overflow and rsp_id stable while rsp_valid=1 and rsp_ready=0 (backpressure held indefinitely).
REQ-021 SHALL NOT accept a new request in the same cycle as a response handshake; the minimum issue interval is 3 cycles.
REQ-022 SHALL produce sums modulo 2^32, with c_out equal to bit 32 of a+b+c_in, and overflow set when the operand signs are equal and the sum sign differs.
REQ-023 SHALL ignore reqN_valid in CALC and HOLD; a requester holding valid in those states is served in a later IDLE cycle.

Reset
REQ-024 SHALL, while rst_n=0, immediately force:
- state to IDLE.
- rsp_valid, req0_ready and req1_ready to 0.
- rsp_s to 0, rsp_c_out to 0, rsp_overflow to 0 and rsp_id to 0.
- the last-grant pointer to the complement of RR_INIT.
REQ-025 SHALL, when reset asserts during CALC or HOLD, discard the in-flight operation with no response.
REQ-026 SHALL accept the first request in the first IDLE cycle after rst_n deasserts.

Configuration
REQ-027 SHALL, with CLA_ARB_SUB_EN defined, add input ports req0_sub and req1_sub, 1 bit each, captured on accept.
REQ-028 SHALL, when the captured sub bit is 1, drive CLA_32 with b = ~b and c_in = 1, ignoring reqN_c_in, so the result is a-b.
REQ-029 SHALL, without CLA_ARB_SUB_EN, omit req0_sub and req1_sub and perform addition only.

Verification
REQ-030 SHALL cover: req0 only, a=32'h0000000F, b=32'h00000001, c_in=0 -> rsp_valid 2 cycles after accept, rsp_s=32'h00000010, rsp_id=0, rsp_c_out=0.
REQ-031 SHALL cover: both requesters valid for 4 consecutive operations, RR_INIT=0 -> grant order 0,1,0,1; each rsp_id matches its grant.
REQ-032 SHALL cover: a=b=32'h80000000, c_in=0 -> rsp_s=0, rsp_c_out=1, rsp_overflow=1.
REQ-033 SHALL cover: rsp_ready held 0 for 5 cycles in HOLD -> outputs stable, both reqN_ready=0; rsp_ready=1 -> IDLE on the next cycle.
REQ-034 SHALL cover: rst_n pulsed low in CALC -> rsp_valid stays 0, all outputs 0, and a new request is served normally afterwards.
REQ-035 SHALL cover, with CLA_ARB_SUB_EN: a=5, b=7, sub=1 -> rsp_s=32'hFFFFFFFE, rsp_c_out=0.
